// File: rtl/gray_updown_counter_pkg.sv
// Shared constants and the binary-to-Gray helper used by the counter blocks.
package gray_updown_counter_pkg;

  localparam int unsigned DEFAULT_WIDTH = 4;
  localparam int unsigned MAX_WIDTH     = 16;

  // Gray code of a binary word; narrower callers zero-extend into MAX_WIDTH.
  function automatic logic [MAX_WIDTH-1:0] bin2gray_f(input logic [MAX_WIDTH-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

endpackage

// File: rtl/gray_updown_counter_bin2gray.sv
// Combinational binary-to-Gray converter, WIDTH bits wide.
module bin2gray
  import gray_updown_counter_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] bin_i,
  output logic [WIDTH-1:0] gray_o
);

  logic [MAX_WIDTH-1:0] gray_full;

  assign gray_full = bin2gray_f(MAX_WIDTH'(bin_i));
  assign gray_o    = gray_full[WIDTH-1:0];

endmodule

// File: rtl/gray_updown_counter.sv
// Up/down binary counter with registered Gray output, terminal count and wrap pulse.
module gray_updown_counter #(
  parameter int unsigned WIDTH = gray_updown_counter_pkg::DEFAULT_WIDTH
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Enable,
  input  logic             Up,
  input  logic             Load,
  input  logic [WIDTH-1:0] LoadValue,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] G,
  output logic             TC,
  output logic             Wrap
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] g_q;
  logic [WIDTH-1:0] g_d;
  logic             wrap_q;
  logic             wrap_d;
  logic             at_bound;
  logic             tc_c;

  // Terminal count: the enabled, non-load edge that will wrap the counter.
  always_comb begin
    at_bound = 1'b0;
    if (Up) begin
      at_bound = (q_q == {WIDTH{1'b1}});
    end else begin
      at_bound = (q_q == {WIDTH{1'b0}});
    end
    tc_c = Enable & ~Load & at_bound;
  end

  // Next count: load beats enable, enable beats hold.
  always_comb begin
    q_d    = q_q;
    wrap_d = tc_c;
    if (Load) begin
      q_d = LoadValue;
    end else if (Enable) begin
      if (Up) begin
        q_d = q_q + WIDTH'(1);
      end else begin
        q_d = q_q - WIDTH'(1);
      end
    end
  end

  // Gray is derived from the next count so it updates on the same edge as Q.
  bin2gray #(
    .WIDTH (WIDTH)
  ) u_bin2gray (
    .bin_i  (q_d),
    .gray_o (g_d)
  );

  always_ff @(posedge Clock) begin
    if (Reset) begin
      q_q    <= '0;
      g_q    <= '0;
      wrap_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      g_q    <= g_d;
      wrap_q <= wrap_d;
    end
  end

  assign Q    = q_q;
  assign G    = g_q;
  assign TC   = tc_c;
  assign Wrap = wrap_q;

endmodule

// File: tb/tb_gray_updown_counter.sv
// Directed and randomised checks for gray_updown_counter at WIDTH=4.
module tb_gray_updown_counter;

  logic       clk;
  logic       rst;
  logic       en;
  logic       up;
  logic       ld;
  logic [3:0] lv;
  logic [3:0] q;
  logic [3:0] g;
  logic       tc;
  logic       wrap;

  int tests;
  int fails;

  gray_updown_counter #(.WIDTH(4)) dut (
    .Clock     (clk),
    .Reset     (rst),
    .Enable    (en),
    .Up        (up),
    .Load      (ld),
    .LoadValue (lv),
    .Q         (q),
    .G         (g),
    .TC        (tc),
    .Wrap      (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [3:0] v);
    rst = 1'b0; ld = 1'b1; lv = v; en = 1'b0; up = 1'b1;
    step();
    ld = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; ld = 1'b1; lv = 4'hA; en = 1'b1; up = 1'b1;
    step();
    tests++;
    if (q !== 4'd0 || g !== 4'd0 || wrap !== 1'b0) begin
      fails++;
      $display("FAIL reset: Q=%0h G=%0h Wrap=%0b, required 0 0 0", q, g, wrap);
    end
    rst = 1'b0; ld = 1'b0;
  endtask

  task automatic test_up_count();
    logic [3:0] gtab [17];
    logic [3:0] exp_q;
    gtab = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC,
             4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8, 4'h0};
    en = 1'b1; up = 1'b1; ld = 1'b0; rst = 1'b0;
    #1;
    for (int k = 0; k <= 16; k++) begin
      exp_q = 4'(k);
      tests++;
      if (q !== exp_q || g !== gtab[k] || wrap !== (k == 16) || tc !== (k == 15)) begin
        fails++;
        $display("FAIL up_count[%0d]: Q=%0h G=%0h Wrap=%0b TC=%0b, required %0h %0h %0b %0b",
                 k, q, g, wrap, tc, exp_q, gtab[k], (k == 16), (k == 15));
      end
      if (k < 16) step();
    end
    en = 1'b0;
    step();
    tests++;
    if (wrap !== 1'b0 || q !== 4'd0) begin
      fails++;
      $display("FAIL up_wrap_single: Wrap=%0b Q=%0h, required 0 0", wrap, q);
    end
  endtask

  task automatic test_down_wrap();
    en = 1'b1; up = 1'b0; ld = 1'b0;
    #1;
    tests++;
    if (tc !== 1'b1) begin
      fails++;
      $display("FAIL down_tc: TC=%0b, required 1", tc);
    end
    step();
    tests++;
    if (q !== 4'hF || g !== 4'h8 || wrap !== 1'b1) begin
      fails++;
      $display("FAIL down_wrap: Q=%0h G=%0h Wrap=%0b, required f 8 1", q, g, wrap);
    end
    en = 1'b0;
    step();
    tests++;
    if (q !== 4'hF || wrap !== 1'b0) begin
      fails++;
      $display("FAIL down_wrap_drop: Q=%0h Wrap=%0b, required f 0", q, wrap);
    end
  endtask

  task automatic test_load_priority();
    ld = 1'b1; lv = 4'd9; en = 1'b1; up = 1'b1;
    #1;
    tests++;
    if (tc !== 1'b0) begin
      fails++;
      $display("FAIL load_tc: TC=%0b, required 0", tc);
    end
    step();
    tests++;
    if (q !== 4'd9 || g !== 4'hD || wrap !== 1'b0) begin
      fails++;
      $display("FAIL load_priority: Q=%0h G=%0h Wrap=%0b, required 9 d 0", q, g, wrap);
    end
    ld = 1'b0; en = 1'b0;
  endtask

  task automatic test_load_boundary();
    do_load(4'd14);
    ld = 1'b1; lv = 4'd0; en = 1'b1; up = 1'b1;
    step();
    ld = 1'b1; lv = 4'd15; en = 1'b1; up = 1'b0;
    #1;
    tests++;
    if (q !== 4'd0 || tc !== 1'b0 || wrap !== 1'b0) begin
      fails++;
      $display("FAIL load_cross_up: Q=%0h TC=%0b Wrap=%0b, required 0 0 0", q, tc, wrap);
    end
    step();
    ld = 1'b0; en = 1'b0;
    step();
    tests++;
    if (q !== 4'd15 || g !== 4'h8 || wrap !== 1'b0) begin
      fails++;
      $display("FAIL load_cross_down: Q=%0h G=%0h Wrap=%0b, required f 8 0", q, g, wrap);
    end
  endtask

  task automatic test_hold();
    do_load(4'd6);
    en = 1'b0; up = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      tests++;
      if (q !== 4'd6 || g !== 4'h5 || tc !== 1'b0 || wrap !== 1'b0) begin
        fails++;
        $display("FAIL hold[%0d]: Q=%0h G=%0h TC=%0b Wrap=%0b, required 6 5 0 0", k, q, g, tc, wrap);
      end
    end
  endtask

  task automatic test_mid_reset();
    do_load(4'd5);
    en = 1'b1; up = 1'b1;
    step();
    step();
    tests++;
    if (q !== 4'd7) begin
      fails++;
      $display("FAIL mid_reset_pre: Q=%0h, required 7", q);
    end
    rst = 1'b1; ld = 1'b1; lv = 4'd3;
    step();
    tests++;
    if (q !== 4'd0 || g !== 4'd0 || wrap !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset: Q=%0h G=%0h Wrap=%0b, required 0 0 0", q, g, wrap);
    end
    rst = 1'b0; ld = 1'b0;
    step();
    tests++;
    if (q !== 4'd1 || g !== 4'd1) begin
      fails++;
      $display("FAIL mid_reset_resume: Q=%0h G=%0h, required 1 1", q, g);
    end
    en = 1'b0;
  endtask

  task automatic test_toggle_dir();
    logic [3:0] exp_q [4];
    logic [3:0] exp_g [4];
    exp_q = '{4'd6, 4'd5, 4'd6, 4'd5};
    exp_g = '{4'h5, 4'h7, 4'h5, 4'h7};
    do_load(4'd5);
    en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      up = (k % 2 == 0);
      step();
      tests++;
      if (q !== exp_q[k] || g !== exp_g[k]) begin
        fails++;
        $display("FAIL toggle[%0d]: Q=%0h G=%0h, required %0h %0h", k, q, g, exp_q[k], exp_g[k]);
      end
    end
    en = 1'b0;
  endtask

  task automatic test_random();
    logic [3:0] mq;
    logic [3:0] mg_prev;
    logic       mtc;
    logic       counted;
    do_load(4'd0);
    mq = 4'd0;
    for (int i = 0; i < 300; i++) begin
      en = 1'($urandom_range(0, 1));
      up = 1'($urandom_range(0, 1));
      ld = ($urandom_range(0, 9) == 0);
      lv = 4'($urandom_range(0, 15));
      #1;
      mtc = en && !ld && (up ? (mq == 4'hF) : (mq == 4'h0));
      tests++;
      if (tc !== mtc) begin
        fails++;
        $display("FAIL rand_tc[%0d]: TC=%0b, required %0b", i, tc, mtc);
      end
      mg_prev = mq ^ (mq >> 1);
      counted = 1'b0;
      if (ld) begin
        mq = lv;
      end else if (en) begin
        mq = up ? mq + 4'd1 : mq - 4'd1;
        counted = 1'b1;
      end
      step();
      tests++;
      if (q !== mq || g !== (mq ^ (mq >> 1)) || wrap !== mtc) begin
        fails++;
        $display("FAIL rand[%0d]: Q=%0h G=%0h Wrap=%0b, required %0h %0h %0b",
                 i, q, g, wrap, mq, mq ^ (mq >> 1), mtc);
      end
      if (counted) begin
        tests++;
        if ($countones(g ^ mg_prev) != 1) begin
          fails++;
          $display("FAIL rand_hamming[%0d]: G=%0h prev=%0h, required distance 1", i, g, mg_prev);
        end
      end
    end
    ld = 1'b0; en = 1'b0;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b0; en = 1'b0; up = 1'b1; ld = 1'b0; lv = 4'd0;
    @(negedge clk);
    test_reset();
    test_up_count();
    test_down_wrap();
    test_load_priority();
    test_load_boundary();
    test_hold();
    test_mid_reset();
    test_toggle_dir();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
